load_store_unit: RTL and testbench

Initiator-side data-memory port for the processor core. Accepts one load or store per handshake from the execute stage and drives the word-addressed, byte-enabled memory interface. The memory read is combinational and the write commits on the clock edge. The unit handles byte lane steering, sign/zero extension and splitting of word-crossing accesses into two memory beats. It sits between the core datapath and the 1024-word data memory.

---
 rtl/load_store_unit.sv | 167 ++++++++++++++++
 tb/tb_load_store_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Data-memory port for the core: one load/store per handshake, byte-lane steering,
// sign/zero extension and two-beat splitting of word-crossing accesses.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_out,
    input  logic [31:0] mem_data_in,
    output logic        mem_we,
    output logic [3:0]  mem_byte_enable
);

    // state | meaning
    // IDLE  | ready for a request
    // BEAT0 | first memory word (addr & ~3)
    // BEAT1 | second word of a word-crossing access (addr & ~3) + 4
    // RESP  | one-cycle response pulse
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic        err_q, err_d;

    logic [1:0]  off;
    logic [2:0]  size;
    logic        split;
    logic        req_legal;
    logic [31:0] wmasked;
    logic [63:0] wide;
    logic [7:0]  bmask;
    logic [31:0] base_addr;
    logic [31:0] r;
    logic [31:0] ext;
    logic        beat;

    always_comb begin
        off = addr_q[1:0];
        case (funct3_q[1:0])
            2'b00:   size = 3'd1;
            2'b01:   size = 3'd2;
            default: size = 3'd4;
        endcase
        split = ({1'b0, off} + size) > 3'd4;

        case (size)
            3'd1:    wmasked = wdata_q & 32'h0000_00FF;
            3'd2:    wmasked = wdata_q & 32'h0000_FFFF;
            default: wmasked = wdata_q;
        endcase
        wide  = {32'b0, wmasked} << {off, 3'b000};
        bmask = ((8'd1 << size) - 8'd1) << off;
        base_addr = {addr_q[31:2], 2'b00};

        r = 32'({hi_q, lo_q} >> {off, 3'b000});
        case (funct3_q)
            3'b000:  ext = {{24{r[7]}}, r[7:0]};
            3'b001:  ext = {{16{r[15]}}, r[15:0]};
            3'b100:  ext = {24'b0, r[7:0]};
            3'b101:  ext = {16'b0, r[15:0]};
            default: ext = r;
        endcase
    end

    always_comb begin
        if (req_we)
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        else
            req_legal = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) && (req_funct3 != 3'b111);
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = !req_legal;
                    state_d  = req_legal ? S_BEAT0 : S_RESP;
                end
            end
            S_BEAT0: begin
                lo_d    = mem_data_in;
                hi_d    = 32'b0;
                state_d = split ? S_BEAT1 : S_RESP;
            end
            S_BEAT1: begin
                hi_d    = mem_data_in;
                state_d = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b0;
            addr_q   <= 32'b0;
            wdata_q  <= 32'b0;
            lo_q     <= 32'b0;
            hi_q     <= 32'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            err_q    <= err_d;
        end
    end

    // All outputs are gated by reset so nothing leaks during a reset cycle in any state.
    always_comb begin
        beat            = !reset && ((state_q == S_BEAT0) || (state_q == S_BEAT1));
        req_ready       = !reset && (state_q == S_IDLE);
        resp_valid      = !reset && (state_q == S_RESP);
        resp_error      = resp_valid && err_q;
        resp_rdata      = (resp_valid && !err_q && !we_q) ? ext : 32'b0;
        mem_we          = beat && we_q;
        mem_address     = 32'b0;
        mem_data_out    = 32'b0;
        mem_byte_enable = 4'b0;
        if (beat) begin
            if (state_q == S_BEAT1) begin
                mem_address     = base_addr + 32'd4;
                mem_data_out    = wide[63:32];
                mem_byte_enable = bmask[7:4];
            end else begin
                mem_address     = base_addr;
                mem_data_out    = wide[31:0];
                mem_byte_enable = bmask[3:0];
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 1024-word byte-enabled memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in;
    logic        mem_we;
    logic [3:0]  mem_byte_enable;

    logic [31:0] mem [0:1023];
    int n_checks = 0;
    int n_pass   = 0;

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
        .mem_we(mem_we), .mem_byte_enable(mem_byte_enable)
    );

    always #5 clk = ~clk;

    assign mem_data_in = mem[mem_address[11:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_byte_enable[b]) mem[mem_address[11:2]][b*8 +: 8] = mem_data_out[b*8 +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Presents a request in an IDLE cycle, returns just after the accept edge with
    // the request inputs scrambled so latching is exercised.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        chk("ready_before_accept", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111; req_addr = 32'hA5A5_A5A5; req_wdata = ~wd;
    endtask

    task automatic load1(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
        issue(1'b0, f3, a, 32'h0);
        @(negedge clk);
        chk({tag, "_we"}, {31'b0, mem_we}, 32'd0);
        chk({tag, "_addr"}, mem_address, {a[31:2], 2'b00});
        @(negedge clk);
        chk({tag, "_vld"}, {31'b0, resp_valid}, 32'd1);
        chk({tag, "_data"}, resp_rdata, exp);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_memwe", {31'b0, mem_we}, 32'd0);
        chk("rst_addr", mem_address, 32'h0);
        chk("rst_be", {28'b0, mem_byte_enable}, 32'h0);
        reset = 1'b0;
        #1 chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

        // SW aligned
        issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        @(negedge clk);
        chk("sw_addr", mem_address, 32'h100);
        chk("sw_be", {28'b0, mem_byte_enable}, 32'hF);
        chk("sw_data", mem_data_out, 32'hDEADBEEF);
        chk("sw_we", {31'b0, mem_we}, 32'd1);
        chk("sw_novld", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("sw_vld", {31'b0, resp_valid}, 32'd1);
        chk("sw_rdata", resp_rdata, 32'h0);
        chk("sw_ready_resp", {31'b0, req_ready}, 32'd0);
        chk("sw_resp_memwe", {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        chk("sw_vld_drop", {31'b0, resp_valid}, 32'd0);
        chk("sw_ready_again", {31'b0, req_ready}, 32'd1);
        chk("sw_mem", mem[64], 32'hDEADBEEF);
        load1("lw_after_sw", 3'b010, 32'h100, 32'hDEADBEEF);

        // SB upper lane
        mem[64] = 32'h11223344;
        issue(1'b1, 3'b000, 32'h103, 32'h123456AA);
        @(negedge clk);
        chk("sb_addr", mem_address, 32'h100);
        chk("sb_be", {28'b0, mem_byte_enable}, 32'h8);
        chk("sb_data", mem_data_out, 32'hAA000000);
        @(negedge clk);
        chk("sb_vld", {31'b0, resp_valid}, 32'd1);
        chk("sb_mem", mem[64], 32'hAA223344);

        // sub-word loads with extension
        mem[64] = 32'h80FF7F01;
        load1("lb", 3'b000, 32'h102, 32'hFFFFFFFF);
        load1("lbu", 3'b100, 32'h102, 32'h000000FF);
        load1("lh0", 3'b001, 32'h100, 32'h00007F01);
        load1("lhu", 3'b101, 32'h102, 32'h000080FF);
        load1("lh2", 3'b001, 32'h102, 32'hFFFF80FF);
        load1("lbu1", 3'b100, 32'h101, 32'h0000007F);

        // split LW
        mem[64] = 32'h44332211; mem[65] = 32'h88776655;
        issue(1'b0, 3'b010, 32'h101, 32'h0);
        @(negedge clk);
        chk("lwx_a0", mem_address, 32'h100);
        chk("lwx_we0", {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        chk("lwx_a1", mem_address, 32'h104);
        chk("lwx_we1", {31'b0, mem_we}, 32'd0);
        chk("lwx_novld", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("lwx_vld", {31'b0, resp_valid}, 32'd1);
        chk("lwx_data", resp_rdata, 32'h55443322);

        // split SH wrapping at top of address space
        mem[1023] = 32'h0; mem[0] = 32'h0;
        issue(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000BBAA);
        @(negedge clk);
        chk("shw_a0", mem_address, 32'hFFFFFFFC);
        chk("shw_be0", {28'b0, mem_byte_enable}, 32'h8);
        chk("shw_d0", mem_data_out, 32'hAA000000);
        @(negedge clk);
        chk("shw_a1", mem_address, 32'h0);
        chk("shw_be1", {28'b0, mem_byte_enable}, 32'h1);
        chk("shw_d1", mem_data_out, 32'h000000BB);
        chk("shw_we1", {31'b0, mem_we}, 32'd1);
        @(negedge clk);
        chk("shw_vld", {31'b0, resp_valid}, 32'd1);
        chk("shw_mem_hi", mem[1023], 32'hAA000000);
        chk("shw_mem_lo", mem[0], 32'h000000BB);

        // illegal funct3
        issue(1'b0, 3'b011, 32'h100, 32'h0);
        @(negedge clk);
        chk("ill_ld_vld", {31'b0, resp_valid}, 32'd1);
        chk("ill_ld_err", {31'b0, resp_error}, 32'd1);
        chk("ill_ld_rdata", resp_rdata, 32'h0);
        chk("ill_ld_memwe", {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        chk("ill_ld_err_drop", {31'b0, resp_error}, 32'd0);
        chk("ill_ld_ready", {31'b0, req_ready}, 32'd1);
        mem[64] = 32'h0;
        issue(1'b1, 3'b100, 32'h100, 32'hFFFFFFFF);
        @(negedge clk);
        chk("ill_st_err", {31'b0, resp_error}, 32'd1);
        chk("ill_st_memwe", {31'b0, mem_we}, 32'd0);
        chk("ill_st_mem", mem[64], 32'h0);

        // reset during BEAT0 of a split SW
        mem[64] = 32'h0; mem[65] = 32'h0;
        issue(1'b1, 3'b010, 32'h102, 32'h11223344);
        reset = 1'b1;
        @(negedge clk);
        chk("rsw_memwe", {31'b0, mem_we}, 32'd0);
        chk("rsw_be", {28'b0, mem_byte_enable}, 32'h0);
        @(negedge clk);
        chk("rsw_nobeat1_we", {31'b0, mem_we}, 32'd0);
        chk("rsw_nobeat1_addr", mem_address, 32'h0);
        reset = 1'b0;
        #1 chk("rsw_ready", {31'b0, req_ready}, 32'd1);
        chk("rsw_mem0", mem[64], 32'h0);
        chk("rsw_mem1", mem[65], 32'h0);
        load1("lw_after_rst", 3'b010, 32'h104, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
